// File: rtl/iter_csa_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative carry-save multiplier.
package iter_csa_multiplier_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESOLVE, DONE} state_t;

  function automatic int calc_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Counter holds 0..steps-1; a single-step configuration still needs one bit.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/iter_csa_multiplier_csa_row.sv
// One 3:2 compressor row: carries are moved to the next weight and the top carry falls off.
module csa_compress_row #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = {maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/iter_csa_multiplier.sv
// Sequential signed/unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Define ITER_CSA_MULTIPLIER_EARLY_TERM_EN to end CALC once the remaining multiplier bits are zero.
module iter_csa_multiplier
  import iter_csa_multiplier_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int N  = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_param_check
    $error("iter_csa_multiplier: BITS_PER_CYCLE must divide WIDTH and WIDTH must be 8..64");
  end

  state_t               state;
  logic [2*WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]     b_rem;
  logic [2*WIDTH-1:0]   sum_q;
  logic [2*WIDTH-1:0]   carry_q;
  logic                 neg;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     b_next;
  logic                 calc_last;
  logic [2*WIDTH-1:0]   resolved;
  logic [2*WIDTH-1:0]   next_sum;
  logic [2*WIDTH-1:0]   next_carry;

  // The most negative operand negates to 2^(WIDTH-1), which is still correct as an unsigned magnitude.
  assign mag_a  = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
  assign mag_b  = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
  assign b_next = b_rem >> BITS_PER_CYCLE;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_row
    logic [2*WIDTH-1:0] s_in;
    logic [2*WIDTH-1:0] c_in;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] s_out;
    logic [2*WIDTH-1:0] c_out;

    if (i == 0) begin : g_first
      assign s_in = sum_q;
      assign c_in = carry_q;
    end else begin : g_next
      assign s_in = g_row[i-1].s_out;
      assign c_in = g_row[i-1].c_out;
    end

    assign pp = b_rem[i] ? (a_shift << i) : '0;

    csa_compress_row #(.WIDTH(2*WIDTH)) u_row (
      .a     (s_in),
      .b     (c_in),
      .c     (pp),
      .sum   (s_out),
      .carry (c_out)
    );
  end

  assign next_sum   = g_row[BITS_PER_CYCLE-1].s_out;
  assign next_carry = g_row[BITS_PER_CYCLE-1].c_out;
  assign resolved   = sum_q + carry_q;

`ifdef ITER_CSA_MULTIPLIER_EARLY_TERM_EN
  assign calc_last = (cnt == LAST) || (b_next == '0);
`else
  assign calc_last = (cnt == LAST);
`endif

  // Control and datapath share one register block so the handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      a_shift   <= '0;
      b_rem     <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift  <= {{WIDTH{1'b0}}, mag_a};
            b_rem    <= mag_b;
            neg      <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            sum_q    <= '0;
            carry_q  <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum_q   <= next_sum;
          carry_q <= next_carry;
          a_shift <= a_shift << BITS_PER_CYCLE;
          b_rem   <= b_next;
          cnt     <= cnt + 1'b1;
          if (calc_last) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_p     <= neg ? (~resolved + 1'b1) : resolved;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
